dcache_dm: RTL and testbench



---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_line_ram.sv | 27 ++
 rtl/dcache_dm.sv | 152 +++++++++++++++
 tb/tb_dcache_dm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
// Helpers take a 64-bit word address and the field widths, returning the
// field right-justified; callers truncate to the field width.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL
  } dc_state_e;

  function automatic logic [63:0] offset_of(input logic [63:0] addr,
                                            input int unsigned off_w);
    return addr & ((64'd1 << off_w) - 64'd1);
  endfunction

  function automatic logic [63:0] index_of(input logic [63:0] addr,
                                           input int unsigned off_w,
                                           input int unsigned idx_w);
    return (addr >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] addr,
                                         input int unsigned off_w,
                                         input int unsigned idx_w);
    return addr >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Cache data array: LINES x WORDS words of DATA_W bits.
// Ports: clk; write port (we, w_line, w_word, w_data) updates on rising edge;
// read port (r_line, r_word -> r_data) is asynchronous. Not reset.
module dcache_line_ram #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] w_line,
  input  logic [$clog2(WORDS)-1:0] w_word,
  input  logic [DATA_W-1:0]        w_data,
  input  logic [$clog2(LINES)-1:0] r_line,
  input  logic [$clog2(WORDS)-1:0] r_word,
  output logic [DATA_W-1:0]        r_data
);

  logic [DATA_W-1:0] mem [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[w_line][w_word] <= w_data;
  end

  assign r_data = mem[r_line][r_word];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Core side: req_i/we_i/addr_i/wdata_i in, rdata_o (combinational on hit
// load) and stall_o out. Memory side: one word per mem_req_o/mem_ack_i beat;
// mem_we_o selects write-back (1) or refill (0). Word-addressed throughout.
// Reset rst_ni is asynchronous, active-low.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LINES  = 16,
  parameter int unsigned WORDS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  dc_state_e state;
  logic [OFF_W-1:0] beat;
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_arr [LINES];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  addr_tag;
  logic              hit;
  logic              last_ack;
  logic              stall;
  logic              ram_we;
  logic [OFF_W-1:0]  ram_w_word;
  logic [DATA_W-1:0] ram_w_data;
  logic [OFF_W-1:0]  ram_r_word;
  logic [DATA_W-1:0] ram_r_data;

  assign off      = OFF_W'(offset_of(64'(addr_i), OFF_W));
  assign idx      = IDX_W'(index_of(64'(addr_i), OFF_W, IDX_W));
  assign addr_tag = TAG_W'(tag_of(64'(addr_i), OFF_W, IDX_W));
  assign hit      = req_i & valid[idx] & (tag_arr[idx] == addr_tag);
  assign last_ack = mem_ack_i & (beat == LAST_BEAT);

  // Single write port: core store while idle, refill beat otherwise.
  assign ram_we     = ((state == IDLE) & hit & we_i) | ((state == REFILL) & mem_ack_i);
  assign ram_w_word = (state == IDLE) ? off : beat;
  assign ram_w_data = (state == IDLE) ? wdata_i : mem_rdata_i;
  // Single read port: victim word during write-back, core word otherwise.
  assign ram_r_word = (state == WB) ? beat : off;

  dcache_line_ram #(
    .LINES (LINES),
    .WORDS (WORDS),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .w_line(idx),
    .w_word(ram_w_word),
    .w_data(ram_w_data),
    .r_line(idx),
    .r_word(ram_r_word),
    .r_data(ram_r_data)
  );

  always_comb begin
    stall       = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state)
      IDLE: begin
        stall   = req_i & ~hit;
        rdata_o = (hit & ~we_i) ? ram_r_data : '0;
      end
      WB: begin
        stall       = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_arr[idx], idx, beat};
        mem_wdata_o = ram_r_data;
      end
      REFILL: begin
        stall      = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_tag, idx, beat};
      end
      default: stall = 1'b0;
    endcase
  end

  // While reset is held every output reads 0, even with a request pending.
  assign stall_o = stall & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      beat  <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i & ~hit) begin
            beat  <= '0;
            state <= (valid[idx] & dirty[idx]) ? WB : REFILL;
          end else if (hit & we_i) begin
            dirty[idx] <= 1'b1;
          end
        end
        WB: begin
          if (mem_ack_i) beat <= beat + OFF_W'(1);
          if (last_ack) begin
            dirty[idx] <= 1'b0;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack_i) beat <= beat + OFF_W'(1);
          if (last_ack) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state == REFILL) && last_ack) tag_arr[idx] <= addr_tag;
  end

endmodule

// File: tb/tb_dcache_dm.sv
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;

  dcache_dm #(
    .ADDR_W(64),
    .DATA_W(64),
    .LINES (16),
    .WORDS (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .stall_o    (stall),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Backing memory model and beat log.
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } beat_t;

  logic [63:0] model [256];
  beat_t       log_q [$];
  int unsigned ack_delay = 0;
  int unsigned wait_cnt = 0;
  logic        spurious = 1'b0;
  logic        pending = 1'b0;
  logic        h_we;
  logic [63:0] h_addr;
  logic [63:0] h_wdata;

  always @(negedge clk) begin
    if (mem_req) begin
      if (pending) begin
        check("hold_we", {63'd0, mem_we}, {63'd0, h_we});
        check("hold_addr", mem_addr, h_addr);
        check("hold_wdata", mem_wdata, h_wdata);
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) model[mem_addr[7:0]] = mem_wdata;
        else mem_rdata = model[mem_addr[7:0]];
        log_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
        wait_cnt = 0;
        pending  = 1'b0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt++;
        pending  = 1'b1;
        h_we     = mem_we;
        h_addr   = mem_addr;
        h_wdata  = mem_wdata;
      end
    end else begin
      mem_ack  = spurious;
      wait_cnt = 0;
      pending  = 1'b0;
    end
  end

  // Holds one access until stall drops; returns stall-cycle count and rdata.
  task automatic access(input logic w, input logic [63:0] a, input logic [63:0] d,
                        output int stalls, output logic [63:0] rd);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    if (stalls >= 300) check("access_timeout", 64'd1, 64'd0);
    rd = rdata;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic check_beat(input int n, input logic w, input logic [63:0] a,
                            input logic [63:0] d, input logic chk_d);
    if (n >= log_q.size()) begin
      check("beat_missing", 64'(n), 64'(log_q.size()));
    end else begin
      check("beat_we", {63'd0, log_q[n].we}, {63'd0, w});
      check("beat_addr", log_q[n].addr, a);
      if (chk_d) check("beat_wdata", log_q[n].wdata, d);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, {63'd0, stall}, 64'd0);
    check({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
    check({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_rdata"}, rdata, 64'd0);
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_stall;
    logic        chk_rdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t        vecs [8];
  int          stalls;
  logic [63:0] rd;
  logic [63:0] wb_exp [4];

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 64'hC0DE_0000_0000_0000 | 64'(i);

    // Hits on line 8 (words 0x20..0x23) after the cold refill.
    vecs[0] = '{1'b1, 1'b0, 64'h22, 64'h0,    1'b0, 1'b1, 64'hC0DE_0000_0000_0022};
    vecs[1] = '{1'b1, 1'b1, 64'h21, 64'hDEAD, 1'b0, 1'b0, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 64'h21, 64'h0,    1'b0, 1'b1, 64'hDEAD};
    vecs[3] = '{1'b1, 1'b1, 64'h23, 64'hBEEF, 1'b0, 1'b0, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 64'h23, 64'h0,    1'b0, 1'b1, 64'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 64'h20, 64'h0,    1'b0, 1'b1, 64'hC0DE_0000_0000_0020};
    vecs[6] = '{1'b0, 1'b0, 64'h55, 64'h0,    1'b0, 1'b0, 64'h0};
    vecs[7] = '{1'b1, 1'b0, 64'h22, 64'h0,    1'b0, 1'b1, 64'hC0DE_0000_0000_0022};

    // Reset state.
    #12;
    check_idle_outputs("reset");
    @(negedge clk); rst_ni = 1'b1;

    // Cold load miss: four refill beats, stall WORDS+1 cycles.
    log_q.delete();
    access(1'b0, 64'h20, 64'h0, stalls, rd);
    check("cold_stalls", 64'(stalls), 64'd5);
    check("cold_rdata", rd, 64'hC0DE_0000_0000_0020);
    check("cold_beats", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_beat(i, 1'b0, 64'h20 + 64'(i), 64'h0, 1'b0);

    // Hit table, with acks arriving while idle to show they are ignored.
    log_q.delete();
    spurious = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), {63'd0, stall}, {63'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_mem_req", i), {63'd0, mem_req}, 64'd0);
      if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; spurious = 1'b0;
    check("hits_no_traffic", 64'(log_q.size()), 64'd0);

    // Dirty miss with slow memory: 8 beats of 4 cycles each plus the request cycle.
    log_q.delete();
    ack_delay = 3;
    access(1'b0, 64'h61, 64'h0, stalls, rd);
    check("dirty_stalls", 64'(stalls), 64'd33);
    check("dirty_rdata", rd, 64'hC0DE_0000_0000_0061);
    check("dirty_beats", 64'(log_q.size()), 64'd8);
    wb_exp[0] = 64'hC0DE_0000_0000_0020;
    wb_exp[1] = 64'hDEAD;
    wb_exp[2] = 64'hC0DE_0000_0000_0022;
    wb_exp[3] = 64'hBEEF;
    for (int i = 0; i < 4; i++) check_beat(i, 1'b1, 64'h20 + 64'(i), wb_exp[i], 1'b1);
    for (int i = 0; i < 4; i++) check_beat(4 + i, 1'b0, 64'h60 + 64'(i), 64'h0, 1'b0);

    // Fast dirty-free miss: line 8 now clean, so only a refill.
    ack_delay = 0;
    log_q.delete();
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 64'h20;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (log_q.size() >= 2) break;
    end
    check("abort_two_beats", 64'(log_q.size()), 64'd2);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("abort");
    req = 1'b0;
    @(negedge clk); rst_ni = 1'b1;

    // After reset the line is invalid again: full refill from 0x20.
    log_q.delete();
    access(1'b0, 64'h20, 64'h0, stalls, rd);
    check("rearm_stalls", 64'(stalls), 64'd5);
    check("rearm_rdata", rd, 64'hC0DE_0000_0000_0020);
    check_beat(0, 1'b0, 64'h20, 64'h0, 1'b0);
    check_beat(3, 1'b0, 64'h23, 64'h0, 1'b0);
    access(1'b0, 64'h21, 64'h0, stalls, rd);
    check("written_back_hit", 64'(stalls), 64'd0);
    check("written_back_data", rd, 64'hDEAD);

    // Store miss to a clean victim: write-allocate then merge.
    log_q.delete();
    access(1'b1, 64'h40, 64'h5555, stalls, rd);
    check("stmiss_stalls", 64'(stalls), 64'd5);
    check("stmiss_beats", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_beat(i, 1'b0, 64'h40 + 64'(i), 64'h0, 1'b0);
    access(1'b0, 64'h40, 64'h0, stalls, rd);
    check("stmiss_load_stalls", 64'(stalls), 64'd0);
    check("stmiss_load_data", rd, 64'h5555);
    check("stmiss_model_untouched", model[8'h40], 64'hC0DE_0000_0000_0040);

    // Line 0 must now be dirty: a conflicting load writes it back first.
    log_q.delete();
    access(1'b0, 64'h80, 64'h0, stalls, rd);
    check("evict_stalls", 64'(stalls), 64'd9);
    check("evict_beats", 64'(log_q.size()), 64'd8);
    check_beat(0, 1'b1, 64'h40, 64'h5555, 1'b1);
    check_beat(1, 1'b1, 64'h41, 64'hC0DE_0000_0000_0041, 1'b1);
    check_beat(4, 1'b0, 64'h80, 64'h0, 1'b0);
    check("evict_rdata", rd, 64'hC0DE_0000_0000_0080);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
